// File: rtl/aer_to_obi.sv
// Receive-side AER-to-OBI bridge: captures tinyODIN output spikes over a 4-phase
// handshake into an event FIFO and exposes them through DATA/STATUS/CTRL registers.
package aer_to_obi_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_rsp_t;
endpackage

module aer_to_obi #(
  parameter type         req_t      = aer_to_obi_pkg::obi_req_t,
  parameter type         rsp_t      = aer_to_obi_pkg::obi_rsp_t,
  parameter int unsigned NUM_NEU    = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  req_t               obi_req_i,
  output rsp_t               obi_resp_o,
  input  logic [NUM_NEU-1:0] AEROUT_ADDR,
  input  logic               AEROUT_REQ,
  output logic               AEROUT_ACK,
  output logic               event_irq_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic {IDLE, WAIT_LOW} state_t;

  state_t             state_q, state_d;
  logic               req_meta_q, req_s_q;
  logic               ack_q, ack_d;
  logic               enable_q, enable_d;
  logic               rvalid_q, rvalid_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [NUM_NEU-1:0] mem_q [FIFO_DEPTH];

  logic               empty, full, push, pop, flush;
  logic [1:0]         reg_sel;
  logic [NUM_NEU-1:0] head;
  logic               unused_bits;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign reg_sel = obi_req_i.addr[3:2];
  assign head    = mem_q[rd_ptr_q];
  assign unused_bits = ^{obi_req_i.be, obi_req_i.addr[31:4], obi_req_i.addr[1:0],
                         obi_req_i.wdata[31:2]};

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        ack_d = 1'b0;
        // Full is the pre-pop flag, so a concurrent pop delays the capture one cycle.
        if (req_s_q && enable_q && !full) begin
          push    = 1'b1;
          ack_d   = 1'b1;
          state_d = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!req_s_q) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop      = obi_req_i.req && !obi_req_i.we && (reg_sel == 2'd0) && !empty;
    flush    = obi_req_i.req && obi_req_i.we && (reg_sel == 2'd2) && obi_req_i.wdata[1];
    enable_d = enable_q;
    if (obi_req_i.req && obi_req_i.we && (reg_sel == 2'd2)) begin
      enable_d = obi_req_i.wdata[0];
    end

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end

    rvalid_d = obi_req_i.req;
    rdata_d  = '0;
    if (obi_req_i.req && !obi_req_i.we) begin
      case (reg_sel)
        2'd0: if (!empty) rdata_d = {1'b1, {(31-NUM_NEU){1'b0}}, head};
        2'd1: rdata_d = {14'b0, full, empty, {(16-CW){1'b0}}, count_q};
        2'd2: rdata_d = {31'b0, enable_q};
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_meta_q <= 1'b0;
      req_s_q    <= 1'b0;
      state_q    <= IDLE;
      ack_q      <= 1'b0;
      enable_q   <= 1'b1;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      req_meta_q <= AEROUT_REQ;
      req_s_q    <= req_meta_q;
      state_q    <= state_d;
      ack_q      <= ack_d;
      enable_q   <= enable_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= AEROUT_ADDR;
  end

  always_comb begin
    obi_resp_o        = '0;
    obi_resp_o.gnt    = obi_req_i.req;
    obi_resp_o.rvalid = rvalid_q;
    obi_resp_o.rdata  = rdata_q;
  end

  assign AEROUT_ACK  = ack_q;
  assign event_irq_o = enable_q && !empty;

endmodule

// File: tb/tb_aer_to_obi.sv
// Directed bench for aer_to_obi: AER capture latency, backpressure, register map,
// enable/flush, push/pop concurrency and asynchronous reset mid-handshake.
module tb_aer_to_obi;
  logic clk = 1'b0;
  logic rst = 1'b1;
  aer_to_obi_pkg::obi_req_t obi_req;
  aer_to_obi_pkg::obi_rsp_t obi_rsp;
  logic [7:0] aer_addr = '0;
  logic aer_req = 1'b0;
  logic aer_ack;
  logic irq;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [31:0] A_DATA = 32'h0, A_STAT = 32'h4, A_CTRL = 32'h8, A_RSVD = 32'hC;

  aer_to_obi dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .obi_req_i   (obi_req),
    .obi_resp_o  (obi_rsp),
    .AEROUT_ADDR (aer_addr),
    .AEROUT_REQ  (aer_req),
    .AEROUT_ACK  (aer_ack),
    .event_irq_o (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic obi_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    obi_req.req = 1'b1; obi_req.we = 1'b0; obi_req.addr = a; obi_req.wdata = '0;
    #1 check("gnt", {31'b0, obi_rsp.gnt}, 32'h1);
    @(posedge clk); #1;
    check("rvalid_rd", {31'b0, obi_rsp.rvalid}, 32'h1);
    d = obi_rsp.rdata;
    obi_req.req = 1'b0;
  endtask

  task automatic obi_write(input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    obi_req.req = 1'b1; obi_req.we = 1'b1; obi_req.addr = a; obi_req.wdata = wd;
    @(posedge clk); #1;
    check("rvalid_wr", {31'b0, obi_rsp.rvalid}, 32'h1);
    obi_req.req = 1'b0; obi_req.we = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    obi_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic wait_ack(input logic lvl, input int max_cyc, input string tag);
    int n = 0;
    while (aer_ack !== lvl && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, {31'b0, aer_ack}, {31'b0, lvl});
  endtask

  task automatic send_event(input logic [7:0] a);
    @(negedge clk);
    aer_addr = a; aer_req = 1'b1;
    wait_ack(1'b1, 8, "send_ack_hi");
    @(negedge clk);
    aer_req = 1'b0;
    wait_ack(1'b0, 8, "send_ack_lo");
  endtask

  initial begin
    logic any_ack;
    obi_req = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'b0, aer_ack}, 32'h0);
    check("rst_rvalid", {31'b0, obi_rsp.rvalid}, 32'h0);
    check("rst_rdata", obi_rsp.rdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    @(negedge clk); rst = 1'b0;
    read_check("rst_status", A_STAT, 32'h0001_0000);
    read_check("rst_ctrl", A_CTRL, 32'h1);
    read_check("rsvd_read", A_RSVD, 32'h0);

    // Single event with exact ACK latency
    @(negedge clk); aer_addr = 8'h5A; aer_req = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("lat_ack_edge2", {31'b0, aer_ack}, 32'h0);
    @(posedge clk); #1;
    check("lat_ack_edge3", {31'b0, aer_ack}, 32'h1);
    check("irq_rise", {31'b0, irq}, 32'h1);
    @(negedge clk); aer_req = 1'b0;
    wait_ack(1'b0, 3, "single_ack_lo");
    read_check("single_status", A_STAT, 32'h0000_0001);
    read_check("single_data", A_DATA, 32'h8000_005A);
    check("irq_fall", {31'b0, irq}, 32'h0);
    read_check("single_status_empty", A_STAT, 32'h0001_0000);

    // Empty read and write to a read-only register
    read_check("empty_data", A_DATA, 32'h0);
    obi_write(A_DATA, 32'hFFFF_FFFF);
    read_check("empty_status", A_STAT, 32'h0001_0000);

    // Backpressure: 16 events fill, the 17th waits for a pop
    for (int i = 0; i < 16; i++) send_event(8'h10 + 8'(i));
    @(negedge clk); aer_addr = 8'h77; aer_req = 1'b1;
    any_ack = 1'b0;
    repeat (10) begin @(posedge clk); #1; any_ack |= aer_ack; end
    check("bp_no_ack", {31'b0, any_ack}, 32'h0);
    read_check("bp_status_full", A_STAT, 32'h0002_0010);
    check("bp_irq", {31'b0, irq}, 32'h1);
    read_check("bp_first", A_DATA, 32'h8000_0010);
    wait_ack(1'b1, 4, "bp_ack_after_pop");
    @(negedge clk); aer_req = 1'b0;
    wait_ack(1'b0, 8, "bp_ack_lo");
    for (int i = 1; i < 16; i++)
      read_check($sformatf("bp_order_%0d", i), A_DATA, 32'h8000_0010 + 32'(i));
    read_check("bp_order_17th", A_DATA, 32'h8000_0077);
    read_check("bp_status_empty", A_STAT, 32'h0001_0000);

    // Enable gating and flush
    obi_write(A_CTRL, 32'h0);
    @(negedge clk); aer_addr = 8'h33; aer_req = 1'b1;
    any_ack = 1'b0;
    repeat (20) begin @(posedge clk); #1; any_ack |= aer_ack; end
    check("dis_no_ack", {31'b0, any_ack}, 32'h0);
    check("dis_irq", {31'b0, irq}, 32'h0);
    obi_write(A_CTRL, 32'h1);
    wait_ack(1'b1, 4, "en_ack");
    @(negedge clk); aer_req = 1'b0;
    wait_ack(1'b0, 8, "en_ack_lo");
    for (int i = 0; i < 3; i++) send_event(8'h34 + 8'(i));
    read_check("flush_pre_status", A_STAT, 32'h0000_0004);
    obi_write(A_CTRL, 32'h3);
    read_check("flush_status", A_STAT, 32'h0001_0000);
    read_check("flush_ctrl", A_CTRL, 32'h1);

    // Concurrent push and pop at count=15
    for (int i = 0; i < 15; i++) send_event(8'h40 + 8'(i));
    @(negedge clk); aer_addr = 8'h4F; aer_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); obi_req.req = 1'b1; obi_req.we = 1'b0; obi_req.addr = A_DATA;
    @(posedge clk); #1;
    check("c15_ack", {31'b0, aer_ack}, 32'h1);
    check("c15_rdata", obi_rsp.rdata, 32'h8000_0040);
    obi_req.req = 1'b0;
    read_check("c15_status", A_STAT, 32'h0000_000F);
    @(negedge clk); aer_req = 1'b0;
    wait_ack(1'b0, 8, "c15_ack_lo");

    // Concurrent push and pop at count=16: pop wins, ACK one cycle later
    send_event(8'h50);
    @(negedge clk); aer_addr = 8'h51; aer_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); obi_req.req = 1'b1; obi_req.we = 1'b0; obi_req.addr = A_DATA;
    @(posedge clk); #1;
    check("c16_ack_held", {31'b0, aer_ack}, 32'h0);
    check("c16_rdata", obi_rsp.rdata, 32'h8000_0041);
    obi_req.req = 1'b0;
    @(posedge clk); #1;
    check("c16_ack_late", {31'b0, aer_ack}, 32'h1);
    read_check("c16_status", A_STAT, 32'h0002_0010);
    @(negedge clk); aer_req = 1'b0;
    wait_ack(1'b0, 8, "c16_ack_lo");
    for (int i = 0; i < 14; i++)
      read_check($sformatf("c_order_%0d", i), A_DATA, 32'h8000_0042 + 32'(i));
    read_check("c_order_50", A_DATA, 32'h8000_0050);
    read_check("c_order_51", A_DATA, 32'h8000_0051);
    read_check("c_status_empty", A_STAT, 32'h0001_0000);

    // Asynchronous reset mid-handshake
    @(negedge clk); aer_addr = 8'h60; aer_req = 1'b1;
    wait_ack(1'b1, 8, "rst_hs_ack");
    obi_write(A_CTRL, 32'h0);
    check("rst_hs_ack_kept", {31'b0, aer_ack}, 32'h1);
    @(negedge clk); #2 rst = 1'b1;
    #1 check("rst_async_ack", {31'b0, aer_ack}, 32'h0);
    aer_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    read_check("rst_hs_status", A_STAT, 32'h0001_0000);
    read_check("rst_hs_ctrl", A_CTRL, 32'h1);
    check("rst_hs_irq", {31'b0, irq}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/aer_to_obi.md
Name: aer_to_obi

Overview:
- Receives output spike events from the tinyODIN core over its 4-phase AER output bundle (AEROUT_ADDR/REQ/ACK).
- Buffers events in a FIFO and exposes them to the CPU through an OBI slave register port: data, status and control.
- Together with the OBI-to-AERIN bridge it completes the processor-to-ODIN link; receive side only.

Parameters:
- req_t, logic, OBI request struct type (req, we, be, addr, wdata).
- rsp_t, logic, OBI response struct type (gnt, rvalid, rdata).
- NUM_NEU, 8, AEROUT address width in bits (neuron index).
- FIFO_DEPTH, 16, event FIFO entries; power of two, at least 2.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous reset, active-high.
- obi_req_i  in  req_t  OBI slave request from the bus.
- obi_resp_o  out  rsp_t  OBI slave response.
- AEROUT_ADDR  in  NUM_NEU  spiking neuron address (bundled data, stable while REQ is high).
- AEROUT_REQ  in  1  AER request from ODIN (asynchronous to clk_i).
- AEROUT_ACK  out  1  AER acknowledge to ODIN (registered).
- event_irq_o  out  1  high while the FIFO is non-empty and enable=1.

Behaviour:
- Reset values: AEROUT_ACK=0, obi_resp_o.rvalid=0, obi_resp_o.rdata=0, FIFO empty, event_irq_o=0, enable=1, FSM=IDLE, synchroniser flops=0.
- AEROUT_REQ passes through a 2-flop synchroniser to give req_s. AEROUT_ADDR is sampled directly at capture time; it is bundled data.
- FSM IDLE:
  - Condition: req_s=1, enable=1 and FIFO not full (full flag of the current cycle).
  - Action: push AEROUT_ADDR, set ACK=1, go to WAIT_LOW.
  - Otherwise stay in IDLE with ACK=0. This is backpressure: no event is ever dropped because the FIFO is full.
- FSM WAIT_LOW: when req_s=0, set ACK=0 and go to IDLE.
- Latency: AEROUT_REQ rising before clock edge 1 gives ACK=1 after edge 3, provided the FIFO is not full.
- OBI port:
  - gnt = obi_req_i.req, combinationally (no stall).
  - rvalid is asserted in the cycle after a granted request, for reads and writes alike.
  - rdata is registered and valid with rvalid. be is ignored.
- Register map, decoded on addr[3:2]:
  - 0x0 DATA (RO): bit31 = valid, bits[NUM_NEU-1:0] = head address, other bits 0. A granted read with the FIFO non-empty pops the head. A read with the FIFO empty returns 0 and does not pop.
  - 0x4 STATUS (RO): bits[15:0] = entry count, bit16 = empty, bit17 = full.
  - 0x8 CTRL (RW): bit0 = enable. bit1 = flush; writing 1 clears the FIFO, self-clears and reads as 0.
  - 0xC: reads return 0.
  - Writes to RO addresses are ignored but still produce rvalid.
- Simultaneous push and pop:
  - FIFO neither empty nor full: both occur, count unchanged.
  - FIFO full: pop only; the push is retried next cycle and ACK is delayed by one cycle.
  - FIFO empty: push only. The DATA read in that cycle returns valid=0.
- Flush in the same cycle as a push: flush wins and the pushed event is discarded (documented loss). A pending DATA read in that cycle returns the pre-flush head.
- enable=0: no new captures, so ODIN stalls. A handshake already in WAIT_LOW completes normally. FIFO contents stay readable.
- Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1. Count never exceeds FIFO_DEPTH.
- Reset mid-handshake: ACK drops immediately (asynchronously) and FIFO contents are lost. If AEROUT_REQ is still high after reset release, it is treated as a new event; ODIN-side duplication is acceptable.

Test Plan:
- Single event: AEROUT_ADDR=0x5A with REQ raised -> ACK high after 3 edges; drop REQ -> ACK low within 3 edges; STATUS=0x00000001; DATA read -> 0x8000005A; STATUS -> 0x00010000; event_irq_o rises then falls.
- Backpressure (FIFO_DEPTH=16): send 17 events without reading -> the 17th REQ stays unacknowledged and STATUS shows count=16, full=1. One DATA read -> the 17th is acknowledged and reading all 16 returns events in order.
- Empty read: DATA read on an empty FIFO -> rdata=0x00000000, rvalid one cycle later, count stays 0.
- Enable/flush: write CTRL=0 then raise REQ -> ACK stays 0 for 20 cycles; write CTRL=1 -> ACK asserted. Then write CTRL=0x3 with 4 events queued -> STATUS empty and CTRL reads 0x1.
- Concurrency: FIFO at count=15, a DATA read in the same cycle as a capture -> count stays 15 and no event is lost. At count=16 with the same stimulus -> pop happens and ACK follows one cycle later.
- Reset mid-handshake: assert rst_i while ACK=1 -> ACK=0 with no clock edge, FIFO empty, CTRL reads 0x1.
